// File: rtl/ev22_pkg.sv
// Shared EV22 pipeline definitions: field widths and the meaning of each Type bit.
package ev22_pkg;

    localparam int unsigned TYPE_W  = 7;
    localparam int unsigned SELA_W  = 5;
    localparam int unsigned SELBC_W = 6;

    localparam logic [TYPE_W-1:0] BUBBLE_TYPE = '0;

    typedef enum logic [2:0] {
        WR_read  = 3'd0,
        WR_write = 3'd1,
        R_read   = 3'd2,
        R_write  = 3'd3,
        C_read   = 3'd4,
        C_write  = 3'd5,
        Jump     = 3'd6
    } type_bit_e;

endpackage

// File: rtl/ev22_stage_reg.sv
// One pipeline stage register: bubble overrides load, otherwise the stage holds its contents.
module ev22_stage_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ev22_pipe_ctrl.sv
// EV22 stage 2..5 pipeline registers with HOLD-driven stall/bubble control,
// a sticky stall watchdog and a wrapping stall-cycle counter.
module ev22_pipe_ctrl
    import ev22_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                nRESET,
    input  logic                IN_VALID,
    input  logic [TYPE_W-1:0]   Type1,
    input  logic [SELA_W-1:0]   SelA1,
    input  logic [SELBC_W-1:0]  SelB1,
    input  logic [SELBC_W-1:0]  SelC1,
    input  logic                HOLD,
    output logic                FETCH_EN,
    output logic [TYPE_W-1:0]   Type2,
    output logic [SELA_W-1:0]   SelA2,
    output logic [SELBC_W-1:0]  SelB2,
    output logic [SELBC_W-1:0]  SelC2,
    output logic [TYPE_W-1:0]   Type3,
    output logic [TYPE_W-1:0]   Type4,
    output logic [TYPE_W-1:0]   Type5,
    output logic [SELBC_W-1:0]  SelC3,
    output logic [SELBC_W-1:0]  SelC4,
    output logic [SELBC_W-1:0]  SelC5,
    output logic                STALL_ERR,
    output logic [CNT_W-1:0]    STALL_CNT
);

    localparam int unsigned S2_W = TYPE_W + SELA_W + 2 * SELBC_W;
    localparam int unsigned SN_W = TYPE_W + SELBC_W;
    localparam int unsigned HC_W = $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HC_MAX  = HC_W'(MAX_HOLD);
    localparam logic [HC_W-1:0] HC_TRIP = HC_W'(MAX_HOLD - 1);

    logic [S2_W-1:0] s2_q;
    logic [SN_W-1:0] s3_q, s4_q, s5_q;
    logic [HC_W-1:0] hold_cnt;

    assign FETCH_EN = !HOLD;

    // Stage 2 freezes under HOLD; with no HOLD an invalid slot enters as a bubble.
    ev22_stage_reg #(.W(S2_W)) u_s2 (
        .clk    (CLK),
        .rst_n  (nRESET),
        .load   (!HOLD),
        .bubble (!HOLD && !IN_VALID),
        .d      ({Type1, SelA1, SelB1, SelC1}),
        .q      (s2_q)
    );

    ev22_stage_reg #(.W(SN_W)) u_s3 (
        .clk    (CLK),
        .rst_n  (nRESET),
        .load   (1'b1),
        .bubble (HOLD),
        .d      ({Type2, SelC2}),
        .q      (s3_q)
    );

    ev22_stage_reg #(.W(SN_W)) u_s4 (
        .clk    (CLK),
        .rst_n  (nRESET),
        .load   (1'b1),
        .bubble (1'b0),
        .d      (s3_q),
        .q      (s4_q)
    );

    ev22_stage_reg #(.W(SN_W)) u_s5 (
        .clk    (CLK),
        .rst_n  (nRESET),
        .load   (1'b1),
        .bubble (1'b0),
        .d      (s4_q),
        .q      (s5_q)
    );

    assign {Type2, SelA2, SelB2, SelC2} = s2_q;
    assign {Type3, SelC3} = s3_q;
    assign {Type4, SelC4} = s4_q;
    assign {Type5, SelC5} = s5_q;

    // hold_cnt saturates at MAX_HOLD; the flag trips on the edge that reaches it.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            hold_cnt  <= '0;
            STALL_ERR <= 1'b0;
            STALL_CNT <= '0;
        end else if (HOLD) begin
            STALL_CNT <= STALL_CNT + CNT_W'(1);
            if (hold_cnt != HC_MAX) begin
                hold_cnt <= hold_cnt + HC_W'(1);
            end
            if (hold_cnt == HC_TRIP) begin
                STALL_ERR <= 1'b1;
            end
        end else begin
            hold_cnt <= '0;
        end
    end

endmodule

// File: doc/ev22_pipe_ctrl.md
Name: ev22_pipe_ctrl

Overview:
- Pipeline-register and stall-control block for the EV22 core. Sits directly downstream of the hazard unit and consumes its HOLD output.
- Holds the stage-2 decoded instruction, inserts bubbles into stage 3 while HOLD is high, and shifts Type/SelC through stages 3→4→5.
- Its registered outputs feed the hazard unit's Type2..Type5, SelA2, SelB2 and SelC3..SelC5 inputs and gate fetch.
- Also provides a stall watchdog and a stall-cycle counter.

Parameters:
- MAX_HOLD, 8: consecutive HOLD cycles that raise STALL_ERR.
- CNT_W, 16: width of the STALL_CNT performance counter.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  stage-1 instruction valid.
- Type1  in  7  stage-1 one-hot-ish type flags (bit 0 WR_read … bit 6 Jump).
- SelA1  in  5  stage-1 register A select.
- SelB1  in  6  stage-1 B select.
- SelC1  in  6  stage-1 destination select.
- HOLD  in  1  stall request from the hazard unit (combinational from this block's outputs).
- FETCH_EN  out  1  stage-1 advance enable; equals !HOLD.
- Type2  out  7  stage-2 type.
- SelA2  out  5  stage-2 A select.
- SelB2  out  6  stage-2 B select.
- SelC2  out  6  stage-2 destination select.
- Type3, Type4, Type5  out  7 each  types for stages 3, 4 and 5.
- SelC3, SelC4, SelC5  out  6 each  destination selects for stages 3, 4 and 5.
- STALL_ERR  out  1  sticky watchdog flag.
- STALL_CNT  out  CNT_W  total stalled cycles, wraps.

Behaviour:
- Reset (nRESET=0, async): every Type and Sel output is 0 (all stages are bubbles). hold_cnt=0, STALL_ERR=0, STALL_CNT=0.
- Bubble definition: Type=0 and all Sel fields=0. A bubble never creates a hazard.
- Stage 2 entry, HOLD=0 on the edge:
  - If IN_VALID=1, stage 2 loads {Type1, SelA1, SelB1, SelC1}.
  - If IN_VALID=0, stage 2 loads a bubble.
- Stage 2, HOLD=1: stage 2 keeps its contents unchanged.
- Stage 3:
  - HOLD=0: stage 3 loads {Type2, SelC2}.
  - HOLD=1: stage 3 loads a bubble.
- Stages 4 and 5 always advance: S4←S3, S5←S4, regardless of HOLD.
- Latency: an instruction accepted at edge N appears in stage 2 after edge N, stage 3 after N+1, stage 5 after N+3, plus one cycle per HOLD cycle spent in stage 2.
- FETCH_EN: combinational !HOLD. Upstream must not advance while HOLD=1; IN_VALID during HOLD is ignored, with no data loss because stage 1 is frozen.
- Jump drain: a Jump in stage 2 holds until stages 3–5 are all bubbles. With this block that takes at most 3 cycles, then it proceeds.
- Watchdog (hold_cnt, saturating at MAX_HOLD):
  - hold_cnt increments on each edge with HOLD=1 and clears on each edge with HOLD=0.
  - When the increment makes hold_cnt == MAX_HOLD, STALL_ERR sets; it clears only on reset.
- STALL_CNT: +1 on each edge with HOLD=1; wraps from 2^CNT_W−1 to 0.
- Reset mid-stall: all stages return to bubbles immediately and hold_cnt clears. The instruction in stage 2 is discarded.
- HOLD is sampled only at the rising edge, so a combinational loop through the hazard unit must settle within the cycle. This block has no combinational path from HOLD to the Type/Sel outputs, so there is no loop.

Decomposition:
- Shared package ev22_pkg:
  - type-bit indices WR_read=0, WR_write=1, R_read=2, R_write=3, C_read=4, C_write=5, Jump=6;
  - TYPE_W=7, SELA_W=5, SELBC_W=6;
  - BUBBLE_TYPE=0.
- One sub-module is natural: ev22_stage_reg, a parameterised-width pipeline register with load/bubble/hold controls. Instantiate it for stages 2, 3, 4 and 5.

Test Plan:
- Reset then 4 cycles of IN_VALID=0, HOLD=0 → all Type2..Type5 = 0, STALL_CNT = 0.
- Issue Type1=7'b0001000 (R_write), SelC1=6'd5 at edge 1, HOLD=0 → Type2 after edge 1, Type3/SelC3=5 after edge 2, Type5/SelC5=5 after edge 4.
- Hold for 2 cycles: stage 2 holds R_read with SelA2=5 and HOLD=1 for 2 edges → stage 2 unchanged, two bubbles follow the prior instruction through stage 3, FETCH_EN=0, STALL_CNT=2.
- Jump in stage 2 while stage 3 holds R_write; drive HOLD as the hazard unit would → HOLD persists exactly until Type3=Type4=Type5=0 (3 cycles), then the Jump moves to stage 3.
- HOLD=1 for 8 consecutive edges → STALL_ERR=1 after the 8th; it stays 1 after HOLD drops and clears only on nRESET.
- Assert nRESET low asynchronously mid-stall with valid data in stages 2–5 → all outputs 0 before the next clock edge, STALL_CNT=0.
